da_table_gen: RTL and testbench

DA_TABLE_GEN -- requirements
Module: da_table_gen

---
 rtl/da_pkg.sv | 18 +
 rtl/da_signed_sum.sv | 33 +++
 rtl/da_table_gen.sv | 102 ++++++++++
 tb/tb_da_table_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/da_pkg.sv
// Shared definitions for the distributed-arithmetic (DA) blocks: default
// geometry, entry-width helper and the table-generator state encoding.
package da_pkg;

    localparam int DA_WIDTH_DEF = 8;
    localparam int DA_TAPS_DEF  = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_UPDATE = 1'b1
    } da_state_e;

    // Sum of TAPS WIDTH-bit signed terms needs clog2(TAPS) guard bits.
    function automatic int da_ow(input int width, input int taps);
        return width + $clog2(taps);
    endfunction

endpackage

// File: rtl/da_signed_sum.sv
// Combinational DA table entry: d[0] plus +/- d[i], with the sign of each
// term chosen by bit (i-1) of the entry index k.
module da_signed_sum
    import da_pkg::*;
#(
    parameter  int WIDTH = DA_WIDTH_DEF,
    parameter  int TAPS  = DA_TAPS_DEF,
    localparam int OW    = da_ow(WIDTH, TAPS),
    localparam int AW    = TAPS - 1
) (
    input  logic [TAPS-1:0][WIDTH-1:0] d,
    input  logic [AW-1:0]              k,
    output logic signed [OW-1:0]       sum
);

    logic signed [OW-1:0] acc;
    logic signed [OW-1:0] term;

    always_comb begin
        acc  = {{(OW-WIDTH){d[0][WIDTH-1]}}, d[0]};
        term = '0;
        for (int i = 1; i < TAPS; i++) begin
            term = {{(OW-WIDTH){d[i][WIDTH-1]}}, d[i]};
            if (k[i-1]) begin
                acc = acc - term;
            end else begin
                acc = acc + term;
            end
        end
        sum = acc;
    end

endmodule

// File: rtl/da_table_gen.sv
// DA lookup-table generator: on each accepted sample the delay line shifts and
// the N-entry table is rebuilt one entry per cycle.
//
// state     | meaning
// ST_IDLE   | table matches delay line, ready for a sample
// ST_UPDATE | writing entry k this cycle, k = 0..N-1
module da_table_gen
    import da_pkg::*;
#(
    parameter  int WIDTH = DA_WIDTH_DEF,
    parameter  int TAPS  = DA_TAPS_DEF,
    localparam int OW    = da_ow(WIDTH, TAPS),
    localparam int N     = 1 << (TAPS - 1),
    localparam int AW    = TAPS - 1
) (
    input  logic                 clk,
    input  logic                 r,
    input  logic [WIDTH-1:0]     x,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 half,
    input  logic [AW-1:0]        rd_addr,
    output logic [OW-1:0]        rd_data,
    output logic                 tbl_valid,
    output logic                 busy
);

    da_state_e                   state_q, state_d;
    logic [TAPS-1:0][WIDTH-1:0]  d_q, d_d;
    logic                        half_q, half_d;
    logic [AW-1:0]               k_q, k_d;
    logic [N-1:0][OW-1:0]        tbl_q, tbl_d;

    logic signed [OW-1:0]        sum_w;
    logic signed [OW-1:0]        entry_w;
    logic                        accept_w;

    da_signed_sum #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_sum (
        .d   (d_q),
        .k   (k_q),
        .sum (sum_w)
    );

    // Halving is a floor shift; the unshifted sum already fits in OW bits.
    assign entry_w = half_q ? (sum_w >>> 1) : sum_w;

    assign busy      = (state_q == ST_UPDATE);
    assign in_ready  = !busy;
    assign tbl_valid = (state_q == ST_IDLE);
    assign accept_w  = in_valid && in_ready;
    assign rd_data   = tbl_q[rd_addr];

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        half_d  = half_q;
        k_d     = k_q;
        tbl_d   = tbl_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_w) begin
                    for (int i = TAPS - 1; i >= 1; i--) begin
                        d_d[i] = d_q[i-1];
                    end
                    d_d[0]  = x;
                    half_d  = half;
                    k_d     = '0;
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                tbl_d[k_q] = entry_w;
                if (k_q == AW'(N - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state_q <= ST_IDLE;
            d_q     <= '0;
            half_q  <= 1'b0;
            k_q     <= '0;
            tbl_q   <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            half_q  <= half_d;
            k_q     <= k_d;
            tbl_q   <= tbl_d;
        end
    end

endmodule

// File: tb/tb_da_table_gen.sv
// Bench for da_table_gen: a behavioural model checked every cycle, directed
// sequences with hand-computed entries, then randomized traffic with resets.
module tb_da_table_gen;

    localparam int WIDTH = 8;
    localparam int TAPS  = 3;
    localparam int N     = 4;
    localparam int OW    = 10;

    logic               clk = 1'b0;
    logic               r;
    logic [WIDTH-1:0]   x;
    logic               in_valid;
    logic               in_ready;
    logic               half;
    logic [TAPS-2:0]    rd_addr;
    logic [OW-1:0]      rd_data;
    logic               tbl_valid;
    logic               busy;

    always #5 clk = ~clk;

    da_table_gen #(.WIDTH(WIDTH), .TAPS(TAPS)) dut (
        .clk       (clk),
        .r         (r),
        .x         (x),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .half      (half),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .tbl_valid (tbl_valid),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: delay line, scale flag, published table, table being built and
    // the number of update cycles still to run.
    int md[TAPS];
    bit mhalf;
    int mtbl[N];
    int mnew[N];
    int left;

    function automatic int model_entry(int k);
        int s;
        s = md[0];
        for (int i = 1; i < TAPS; i++) begin
            if (((k >> (i - 1)) & 1) != 0) s = s - md[i];
            else                           s = s + md[i];
        end
        if (mhalf) s = s >>> 1;
        return s;
    endfunction

    task automatic check(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (r) begin
            foreach (md[i]) md[i] = 0;
            foreach (mtbl[i]) begin
                mtbl[i] = 0;
                mnew[i] = 0;
            end
            mhalf = 1'b0;
            left  = 0;
        end else if (left > 0) begin
            left--;
            if (left == 0) mtbl = mnew;
        end else if (in_valid) begin
            for (int i = TAPS - 1; i > 0; i--) md[i] = md[i-1];
            md[0] = int'($signed(x));
            mhalf = half;
            foreach (mnew[k]) mnew[k] = model_entry(k);
            left = N;
        end
    end

    // Entries 0..N-left-1 have been rewritten; the rest still hold old values.
    always @(negedge clk) begin
        int a;
        int exp_rd;
        if (chk_en) begin
            a = int'(rd_addr);
            exp_rd = (a < N - left) ? mnew[a] : mtbl[a];
            check("busy",      int'(busy),      int'(left > 0));
            check("in_ready",  int'(in_ready),  int'(left == 0));
            check("tbl_valid", int'(tbl_valid), int'(left == 0));
            check("rd_data",   int'($signed(rd_data)), exp_rd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int v, bit h);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) check("send_ready_timeout", int'(in_ready), 1);
        x        = WIDTH'(v);
        half     = h;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!tbl_valid && n < 50) begin
            step();
            n++;
        end
        check("wait_tbl_valid", int'(tbl_valid), 1);
    endtask

    task automatic read_chk(int a, int exp, string name);
        step();
        rd_addr = (TAPS - 1)'(a);
        #1;
        check(name, int'($signed(rd_data)), exp);
    endtask

    task automatic pulse_reset();
        r = 1'b1;
        step();
        r = 1'b0;
    endtask

    initial begin
        int nacc;
        r        = 1'b1;
        x        = '0;
        in_valid = 1'b0;
        half     = 1'b0;
        rd_addr  = '0;
        step();
        step();
        chk_en = 1'b1;
        r = 1'b0;

        // Reset state
        for (int a = 0; a < N; a++) begin
            read_chk(a, 0, "reset_entry");
            check("reset_tbl_valid", int'(tbl_valid), 1);
        end

        // 10, 20, 30 with half=0
        send(10, 1'b0); wait_valid();
        send(20, 1'b0); wait_valid();
        send(30, 1'b0); wait_valid();
        read_chk(0, 60, "seq_k0");
        read_chk(1, 20, "seq_k1");
        read_chk(2, 40, "seq_k2");
        read_chk(3, 0,  "seq_k3");

        // Same with half on the last accept, then d = {0, 1, 30}
        pulse_reset();
        send(10, 1'b0); wait_valid();
        send(20, 1'b0); wait_valid();
        send(30, 1'b1); wait_valid();
        read_chk(0, 30, "half_k0");
        read_chk(1, 10, "half_k1");
        read_chk(2, 20, "half_k2");
        read_chk(3, 0,  "half_k3");
        send(1, 1'b1); wait_valid();
        send(0, 1'b1); wait_valid();
        read_chk(3, -16, "half_neg_k3");

        // Extremes
        send(-128, 1'b0); wait_valid();
        send(-128, 1'b0); wait_valid();
        send(-128, 1'b0); wait_valid();
        read_chk(0, -384, "ext_k0");
        read_chk(3, 128,  "ext_k3");
        send(127, 1'b0);  wait_valid();
        send(-128, 1'b0); wait_valid();
        send(-128, 1'b0); wait_valid();
        read_chk(2, -383, "ext_k2");

        // Continuous in_valid with incrementing x: accepts 0,5,10,15,20,25
        nacc = 0;
        for (int c = 0; c < 30; c++) begin
            x        = WIDTH'(c);
            half     = 1'b0;
            in_valid = 1'b1;
            if (in_ready) nacc++;
            step();
        end
        in_valid = 1'b0;
        check("stream_accepts", nacc, 6);
        wait_valid();
        read_chk(0, 60,  "stream_k0");
        read_chk(3, -10, "stream_k3");

        // Reset at update step k=1
        send(50, 1'b0);
        step();
        check("abort_busy_before", int'(busy), 1);
        r = 1'b1;
        step();
        r = 1'b0;
        check("abort_busy",      int'(busy),      0);
        check("abort_tbl_valid", int'(tbl_valid), 1);
        check("abort_in_ready",  int'(in_ready),  1);
        for (int a = 0; a < N; a++) read_chk(a, 0, "abort_entry");

        // Randomized traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            x        = WIDTH'($urandom);
            half     = 1'($urandom_range(0, 1));
            rd_addr  = (TAPS - 1)'($urandom);
            r        = ($urandom_range(0, 49) == 0);
            step();
        end
        r        = 1'b0;
        in_valid = 1'b0;
        wait_valid();
        for (int a = 0; a < N; a++) read_chk(a, mtbl[a], "rand_final_entry");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
